// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD event counter: FSM state, digit limit,
// seven-segment patterns {g..a}, and the single-digit next-value function.
// Latency: n/a (package). Backpressure: n/a.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    localparam logic [6:0] SEG_0   = 7'h3F;
    localparam logic [6:0] SEG_1   = 7'h06;
    localparam logic [6:0] SEG_2   = 7'h5B;
    localparam logic [6:0] SEG_3   = 7'h4F;
    localparam logic [6:0] SEG_4   = 7'h66;
    localparam logic [6:0] SEG_5   = 7'h6D;
    localparam logic [6:0] SEG_6   = 7'h7D;
    localparam logic [6:0] SEG_7   = 7'h07;
    localparam logic [6:0] SEG_8   = 7'h7F;
    localparam logic [6:0] SEG_9   = 7'h6F;
    localparam logic [6:0] SEG_OFF = 7'h00;

    // Out-of-range digits (10..15) also fall back to 0 on increment.
    function automatic logic [3:0] bcd_next(input logic [3:0] d, input logic clr, input logic inc);
        logic [3:0] n;
        n = d;
        if (clr) begin
            n = 4'd0;
        end else if (inc) begin
            n = (d >= BCD_MAX) ? 4'd0 : d + 4'd1;
        end
        return n;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_OFF;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One cascaded BCD digit with synchronous clear and increment enable.
// Latency: 1 cycle from inc_en/clr to digit. Backpressure: none, acts every cycle.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc_en,
    output logic [3:0] digit,
    output logic       at_max
);

    logic [3:0] digit_q;
    logic [3:0] digit_d;

    always_comb begin
        digit_d = bcd_next(digit_q, clr, inc_en);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit  = digit_q;
    assign at_max = (digit_q == BCD_MAX);

endmodule

// File: rtl/bcd_event_counter.sv
// Counts rising edges of tick_in into a NUM_DIGITS BCD register under start/stop/clear control.
// Latency: 1 cycle from first high sample of tick_in to bcd_out. Backpressure: none, no flow control.
// Optional BCD_SEG7_EN macro adds a registered seven-segment output aligned with bcd_out.
module bcd_event_counter
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick_in,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    clear,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic                    carry_out,
`ifdef BCD_SEG7_EN
    output logic [7*NUM_DIGITS-1:0] seg_out,
`endif
    output logic                    running
);

    state_t                state_q;
    state_t                state_d;
    logic                  tick_d_q;
    logic                  carry_q;
    logic                  carry_d;
    logic                  running_q;
    logic                  rise;
    logic                  count_en;
    logic [NUM_DIGITS:0]   en_chain;
    logic [NUM_DIGITS-1:0] at_max;

    assign rise     = tick_in & ~tick_d_q;
    // Only the registered state gates counting: entering RUN ignores a coincident
    // rise, while the stop edge out of RUN still counts it.
    assign count_en = (state_q == RUN) & rise & ~clear;

    assign en_chain[0] = count_en;

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        bcd_digit u_digit (
            .clk    (clk),
            .rst    (rst),
            .clr    (clear),
            .inc_en (en_chain[k]),
            .digit  (bcd_out[4*k +: 4]),
            .at_max (at_max[k])
        );
        assign en_chain[k+1] = en_chain[k] & at_max[k];
    end

    assign carry_d = en_chain[NUM_DIGITS];

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else if (stop) begin
            if (state_q == RUN) begin
                state_d = HOLD;
            end
        end else if (start && (state_q != RUN)) begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            tick_d_q  <= 1'b0;
            carry_q   <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_d_q  <= tick_in;
            carry_q   <= carry_d;
            running_q <= (state_d == RUN);
        end
    end

    assign carry_out = carry_q;
    assign running   = running_q;

`ifdef BCD_SEG7_EN
    logic [7*NUM_DIGITS-1:0] seg_q;
    logic [7*NUM_DIGITS-1:0] seg_d;

    // Decode the digits' next values so segments land on the same edge as bcd_out.
    always_comb begin
        seg_d = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            seg_d[7*k +: 7] = seg_decode(bcd_next(bcd_out[4*k +: 4], clear, en_chain[k]));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_q <= '0;
        end else begin
            seg_q <= seg_d;
        end
    end

    assign seg_out = seg_q;
`endif

endmodule

// File: tb/tb_bcd_event_counter.sv
// Self-checking bench for bcd_event_counter: vector table plus scenario sequences,
// with per-cycle expectations from a decimal reference model queued and compared.
module tb_bcd_event_counter;

    localparam int ND  = 4;
    localparam int MOD = 10000;

    logic clk     = 1'b0;
    logic rst     = 1'b0;
    logic tick_in = 1'b0;
    logic start   = 1'b0;
    logic stop    = 1'b0;
    logic clear   = 1'b0;
    logic [4*ND-1:0] bcd_out;
    logic            carry_out;
    logic            running;
`ifdef BCD_SEG7_EN
    logic [7*ND-1:0] seg_out;
`endif

    int checks     = 0;
    int failures   = 0;
    int carry_seen = 0;

    int   m_st;
    int   m_cnt;
    logic m_tickd;

    typedef struct {
        logic [15:0] bcd;
        logic        carry;
        logic        run;
    } exp_t;

    typedef struct {
        logic        t;
        logic        s;
        logic        p;
        logic        c;
        logic [15:0] bcd;
        logic        carry;
        logic        run;
    } vec_t;

    exp_t sbq[$];
    vec_t tbl[14];

    always #5 clk = ~clk;

    bcd_event_counter #(.NUM_DIGITS(ND)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick_in   (tick_in),
        .start     (start),
        .stop      (stop),
        .clear     (clear),
        .bcd_out   (bcd_out),
        .carry_out (carry_out),
`ifdef BCD_SEG7_EN
        .seg_out   (seg_out),
`endif
        .running   (running)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int d;
        r = '0;
        d = v;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'(d % 10);
            d = d / 10;
        end
        return r;
    endfunction

`ifdef BCD_SEG7_EN
    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] tbl7 [10];
        tbl7 = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        return (d < 4'd10) ? tbl7[d] : 7'h00;
    endfunction
`endif

    task automatic apply(input logic t, input logic s, input logic p, input logic c, input exp_t e);
        exp_t g;
        tick_in = t;
        start   = s;
        stop    = p;
        clear   = c;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        g = sbq.pop_front();
        check("bcd_out", 32'(bcd_out), 32'(g.bcd));
        check("carry_out", 32'(carry_out), 32'(g.carry));
        check("running", 32'(running), 32'(g.run));
`ifdef BCD_SEG7_EN
        for (int i = 0; i < ND; i++) begin
            check("seg_out", 32'(seg_out[7*i +: 7]), 32'(seg_of(g.bcd[4*i +: 4])));
        end
`endif
        if (carry_out) carry_seen++;
    endtask

    task automatic step(input logic t, input logic s, input logic p, input logic c);
        exp_t e;
        logic rise;
        logic en;
        rise    = t & ~m_tickd;
        en      = (m_st == 1) && rise && !c;
        e.carry = en && (m_cnt == MOD - 1);
        if (c) m_cnt = 0;
        else if (en) m_cnt = (m_cnt + 1) % MOD;
        if (c) m_st = 0;
        else if (p) begin
            if (m_st == 1) m_st = 2;
        end else if (s) m_st = 1;
        m_tickd = t;
        e.bcd   = to_bcd(m_cnt);
        e.run   = (m_st == 1);
        apply(t, s, p, c, e);
    endtask

    task automatic rises(input int n, input int half);
        for (int i = 0; i < n; i++) begin
            repeat (half) step(1'b1, 1'b0, 1'b0, 1'b0);
            repeat (half) step(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        tick_in = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        clear   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b1;
        m_st    = 0;
        m_cnt   = 0;
        m_tickd = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_bcd", 32'(bcd_out), 32'h0);
        check("reset_carry", 32'(carry_out), 32'h0);
        check("reset_running", 32'(running), 32'h0);
        rst     = 1'b1;
        m_st    = 0;
        m_cnt   = 0;
        m_tickd = 1'b0;

        //            t     s     p     c     bcd       carry run
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0002, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0};
        for (int i = 0; i < 14; i++) begin
            exp_t e;
            e.bcd   = tbl[i].bcd;
            e.carry = tbl[i].carry;
            e.run   = tbl[i].run;
            apply(tbl[i].t, tbl[i].s, tbl[i].p, tbl[i].c, e);
        end

        // Asynchronous reset mid-count, then release with tick_in already high
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        rises(42, 2);
        check("pre_reset_bcd", 32'(bcd_out), 32'h0042);
        #2;
        rst = 1'b0;
        #1;
        check("async_reset_bcd", 32'(bcd_out), 32'h0);
        check("async_reset_running", 32'(running), 32'h0);
        check("async_reset_carry", 32'(carry_out), 32'h0);
        tick_in = 1'b1;
        @(posedge clk);
        #1;
        rst     = 1'b1;
        m_st    = 0;
        m_cnt   = 0;
        m_tickd = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("high_tick_after_reset", 32'(bcd_out), 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // 25 rises at a 20-cycle period
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        rises(25, 10);
        check("count25_bcd", 32'(bcd_out), 32'h0025);
        check("count25_running", 32'(running), 32'h1);

        // Full cascade and wrap
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        rises(9998, 1);
        check("preload_9998", 32'(bcd_out), 32'h9998);
        carry_seen = 0;
        rises(1, 1);
        check("at_9999", 32'(bcd_out), 32'h9999);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("wrap_bcd", 32'(bcd_out), 32'h0000);
        check("wrap_carry", 32'(carry_out), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("carry_drop", 32'(carry_out), 32'h0);
        check("carry_once", 32'(carry_seen), 32'd1);

        // Hold freezes the count, restart resumes it
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        rises(137, 1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        rises(5, 1);
        check("hold_bcd", 32'(bcd_out), 32'h0137);
        check("hold_running", 32'(running), 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        rises(3, 1);
        check("resume_bcd", 32'(bcd_out), 32'h0140);

        // Control priority
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        rises(500, 1);
        check("pre_clear_bcd", 32'(bcd_out), 32'h0500);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        check("clear_prio_bcd", 32'(bcd_out), 32'h0);
        check("clear_prio_running", 32'(running), 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        rises(2, 1);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check("stop_over_start", 32'(running), 32'h0);
        rises(1, 1);
        check("stop_over_start_bcd", 32'(bcd_out), 32'h0002);

`ifdef BCD_SEG7_EN
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        rises(8, 1);
        check("seg_digit0", 32'(seg_out[6:0]), 32'h7F);
        for (int i = 1; i < ND; i++) begin
            check("seg_upper", 32'(seg_out[7*i +: 7]), 32'h3F);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
